// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder FSM states, default shift width and the
// mode-bit positions used by the master's CR1 register.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2
  } spi_state_e;

  localparam int SPI_DATA_W = 8;

  localparam int CR1_LSBFE = 0;
  localparam int CR1_CPHA  = 1;
  localparam int CR1_CPOL  = 2;
  localparam int MODE_W    = 3;

endpackage

// File: rtl/spi_slave_responder_if.sv
// Pin bundle of the SPI responder: serial link, configuration, TX/RX host side,
// error flags and the FSM state for observation.
interface spi_slave_responder_if #(
  parameter int DATA_W = spi_pkg::SPI_DATA_W
);
  import spi_pkg::*;

  logic              spe_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              lsbfe_i;
  logic              ss_i;
  logic              sclk_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_oe_o;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_load_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              rx_rd_i;
  logic              overrun_o;
  logic              underrun_o;
  logic              abort_o;
  logic              err_clr_i;
  spi_state_e        state;

  // Host handshakes: tx_load_i is taken only in a cycle where tx_ready_o=1;
  // rx_valid_o stays high until a cycle with rx_rd_i=1 (a new byte in that
  // same cycle keeps it high).
  modport slave (
    input  spe_i, cpol_i, cpha_i, lsbfe_i, ss_i, sclk_i, mosi_i,
    input  tx_data_i, tx_load_i, rx_rd_i, err_clr_i,
    output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
    output overrun_o, underrun_o, abort_o, state
  );

  modport master (
    output spe_i, cpol_i, cpha_i, lsbfe_i, ss_i, sclk_i, mosi_i,
    output tx_data_i, tx_load_i, rx_rd_i, err_clr_i,
    input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
    input  overrun_o, underrun_o, abort_o, state
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by one edge-detect
// register; q is the synchronized level, rise/fall are single-cycle strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= STAGES'({chain, d});
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI responder: oversamples ss/sclk/mosi in the PCLK domain and exchanges one
// DATA_W-bit word per frame slot in any CPOL/CPHA mode, MSB or LSB first.
module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter logic [DATA_W-1:0] IDLE_TX     = 8'hFF,
  parameter int                SYNC_STAGES = 2
) (
  input logic                  PCLK,
  input logic                  PRESET_n,
  spi_slave_responder_if.slave bus
);

  localparam int              BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_W - 1);

  spi_state_e             state, state_next;
  logic                   ss_q, ss_rise, ss_fall;
  logic                   sclk_q, sclk_rise, sclk_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   mosi_q;
  logic [BW-1:0]          bit_cnt;
  logic [MODE_W-1:0]      mode_q, mode_in;
  logic [DATA_W-1:0]      shift_tx, shift_rx, tx_hold, rx_data, rx_next, reload_data;
  logic                   tx_full, rx_valid, overrun, underrun, abort_q;
  logic                   skip_shift, uflow_pend;
  logic                   do_load, in_xfer, abort_now;
  logic                   sclk_edge, lead, trail, sample_edge, shift_edge;
  logic                   byte_done, reload, reload_empty;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk(PCLK), .rst_n(PRESET_n), .d(bus.ss_i), .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk(PCLK), .rst_n(PRESET_n), .d(bus.sclk_i), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  // mosi gets the same depth as sclk so a sampled bit lines up with its edge
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) mosi_sync <= '0;
    else           mosi_sync <= SYNC_STAGES'({mosi_sync, bus.mosi_i});
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  assign sclk_edge   = sclk_rise | sclk_fall;
  assign lead        = sclk_edge & (sclk_q ^ mode_q[CR1_CPOL]);
  assign trail       = sclk_edge & ~(sclk_q ^ mode_q[CR1_CPOL]);
  assign sample_edge = mode_q[CR1_CPHA] ? trail : lead;
  assign shift_edge  = mode_q[CR1_CPHA] ? lead : trail;

  always_comb begin
    mode_in            = '0;
    mode_in[CR1_LSBFE] = bus.lsbfe_i;
    mode_in[CR1_CPHA]  = bus.cpha_i;
    mode_in[CR1_CPOL]  = bus.cpol_i;
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    in_xfer    = 1'b0;
    abort_now  = 1'b0;
    case (state)
      IDLE:    if (bus.spe_i && ss_fall) state_next = LOAD;
      LOAD:    begin
        do_load    = 1'b1;
        state_next = XFER;
      end
      XFER:    in_xfer = 1'b1;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && ss_rise) begin
      state_next = IDLE;
      do_load    = 1'b0;
      in_xfer    = 1'b0;
      abort_now  = (bit_cnt != '0);
    end
    if (!bus.spe_i) begin
      state_next = IDLE;
      do_load    = 1'b0;
      in_xfer    = 1'b0;
      abort_now  = 1'b0;
    end
  end

  assign byte_done    = in_xfer & sample_edge & (bit_cnt == LAST_BIT);
  assign reload       = do_load | byte_done;
  assign reload_empty = ~tx_full & ~bus.tx_load_i;
  assign reload_data  = tx_full ? tx_hold : (bus.tx_load_i ? bus.tx_data_i : IDLE_TX);
  assign rx_next      = mode_q[CR1_LSBFE] ? {mosi_q, shift_rx[DATA_W-1:1]}
                                          : {shift_rx[DATA_W-2:0], mosi_q};

  // A reload at byte end only counts as underrun once the master actually
  // starts another byte (its first leading edge); ending the frame is clean.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      bit_cnt    <= '0;
      mode_q     <= '0;
      shift_tx   <= '0;
      shift_rx   <= '0;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      abort_q    <= 1'b0;
      skip_shift <= 1'b0;
      uflow_pend <= 1'b0;
    end else begin
      abort_q <= abort_now;

      if (reload)                              tx_full <= 1'b0;
      else if (bus.tx_load_i && !tx_full) begin
        tx_hold <= bus.tx_data_i;
        tx_full <= 1'b1;
      end

      if (reload) begin
        shift_tx   <= reload_data;
        mode_q     <= mode_in;
        skip_shift <= do_load ? mode_in[CR1_CPHA] : 1'b1;
      end else if (in_xfer && shift_edge) begin
        if (skip_shift)              skip_shift <= 1'b0;
        else if (mode_q[CR1_LSBFE])  shift_tx   <= {1'b0, shift_tx[DATA_W-1:1]};
        else                         shift_tx   <= {shift_tx[DATA_W-2:0], 1'b0};
      end

      if (state_next == IDLE || reload)  bit_cnt <= '0;
      else if (in_xfer && sample_edge)   bit_cnt <= bit_cnt + BW'(1);

      if (in_xfer && sample_edge) shift_rx <= rx_next;

      if (byte_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (bus.rx_rd_i) begin
        rx_valid <= 1'b0;
      end

      if (state_next == IDLE)                 uflow_pend <= 1'b0;
      else if (byte_done)                     uflow_pend <= reload_empty;
      else if (in_xfer && lead)               uflow_pend <= 1'b0;

      overrun  <= (overrun & ~bus.err_clr_i) | (byte_done & rx_valid & ~bus.rx_rd_i);
      underrun <= (underrun & ~bus.err_clr_i) | (do_load & reload_empty)
                | (in_xfer & lead & uflow_pend);
    end
  end

  assign bus.miso_o     = mode_q[CR1_LSBFE] ? shift_tx[0] : shift_tx[DATA_W-1];
  assign bus.miso_oe_o  = bus.spe_i & (state != IDLE) & ~ss_q;
  assign bus.tx_ready_o = ~tx_full;
  assign bus.rx_data_o  = rx_data;
  assign bus.rx_valid_o = rx_valid;
  assign bus.overrun_o  = overrun;
  assign bus.underrun_o = underrun;
  assign bus.abort_o    = abort_q;
  assign bus.state      = state;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: a bit-banged SPI master drives directed frames
// while a monitor pops expected received bytes from a scoreboard queue.
module tb_spi_slave_responder;
  import spi_pkg::*;

  localparam int H = 8;  // PCLK cycles per sclk half period

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   abort_cnt = 0;

  logic [7:0] exp_q[$];
  logic       mon_prev_valid = 1'b0;
  logic [7:0] mon_prev_data = 8'h00;
  logic       m_cpol, m_cpha, m_lsbfe;

  spi_slave_responder_if #(.DATA_W(8)) bus();

  spi_slave_responder dut (
    .PCLK(clk),
    .PRESET_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a new byte is a rise of rx_valid_o or a data change while valid
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev_valid = 1'b0;
    end else begin
      if (bus.rx_valid_o && (!mon_prev_valid || bus.rx_data_o != mon_prev_data)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %02h with nothing expected", bus.rx_data_o);
        end else begin
          check("rx_byte", {24'h0, bus.rx_data_o}, {24'h0, exp_q.pop_front()});
        end
      end
      mon_prev_valid = bus.rx_valid_o;
      mon_prev_data  = bus.rx_data_o;
    end
  end

  always @(negedge clk) if (rst_n && bus.abort_o) abort_cnt++;

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe);
    m_cpol = cpol; m_cpha = cpha; m_lsbfe = lsbfe;
    bus.cpol_i = cpol; bus.cpha_i = cpha; bus.lsbfe_i = lsbfe;
    bus.sclk_i = cpol;
    wait_n(H);
  endtask

  task automatic tx_load(input logic [7:0] d);
    bus.tx_data_i = d;
    bus.tx_load_i = 1'b1;
    wait_n(1);
    bus.tx_load_i = 1'b0;
  endtask

  task automatic rd_pulse();
    bus.rx_rd_i = 1'b1;
    wait_n(1);
    bus.rx_rd_i = 1'b0;
    wait_n(1);
  endtask

  task automatic err_clr_pulse();
    bus.err_clr_i = 1'b1;
    wait_n(1);
    bus.err_clr_i = 1'b0;
    wait_n(1);
  endtask

  task automatic ss_low();
    bus.ss_i = 1'b0;
    wait_n(H);
  endtask

  task automatic ss_high();
    wait_n(H);
    bus.ss_i = 1'b1;
    wait_n(2 * H);
  endtask

  // one byte; rd_on_done pulses rx_rd_i in the cycle the responder completes it
  task automatic spi_byte(input logic [7:0] mo, input logic rd_on_done, output logic [7:0] mi);
    int idx;
    mi = 8'h00;
    for (int i = 0; i < 8; i++) begin
      idx = m_lsbfe ? i : 7 - i;
      if (!m_cpha) begin
        bus.mosi_i = mo[idx];
        wait_n(H);
        bus.sclk_i = ~m_cpol;
        mi[idx] = bus.miso_o;
        if (rd_on_done && i == 7) begin
          wait_n(2);
          bus.rx_rd_i = 1'b1;
          wait_n(1);
          bus.rx_rd_i = 1'b0;
          wait_n(H - 3);
        end else begin
          wait_n(H);
        end
        bus.sclk_i = m_cpol;
      end else begin
        bus.sclk_i = ~m_cpol;
        bus.mosi_i = mo[idx];
        wait_n(H);
        bus.sclk_i = m_cpol;
        mi[idx] = bus.miso_o;
        wait_n(H);
      end
    end
  endtask

  task automatic frame(input logic [7:0] mo, input logic rd_on_done, output logic [7:0] mi);
    ss_low();
    spi_byte(mo, rd_on_done, mi);
    ss_high();
  endtask

  initial begin
    logic [7:0] r0, r1;
    int a0;
    bus.spe_i = 1'b1; bus.ss_i = 1'b1; bus.sclk_i = 1'b0; bus.mosi_i = 1'b0;
    bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.lsbfe_i = 1'b0;
    bus.tx_data_i = 8'h00; bus.tx_load_i = 1'b0; bus.rx_rd_i = 1'b0; bus.err_clr_i = 1'b0;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsbfe = 1'b0;
    rst_n = 1'b0;
    wait_n(3);
    check("rst_miso", {31'h0, bus.miso_o}, 32'h0);
    check("rst_oe", {31'h0, bus.miso_oe_o}, 32'h0);
    check("rst_tx_ready", {31'h0, bus.tx_ready_o}, 32'h1);
    check("rst_rx_data", {24'h0, bus.rx_data_o}, 32'h0);
    check("rst_flags", {28'h0, bus.rx_valid_o, bus.overrun_o, bus.underrun_o, bus.abort_o}, 32'h0);
    check("rst_state", {30'h0, bus.state}, {30'h0, IDLE});
    rst_n = 1'b1;
    wait_n(2);

    // mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    tx_load(8'h18);
    check("tx_ready_after_load", {31'h0, bus.tx_ready_o}, 32'h0);
    exp_q.push_back(8'h33);
    ss_low();
    check("oe_selected", {31'h0, bus.miso_oe_o}, 32'h1);
    spi_byte(8'h33, 1'b0, r0);
    ss_high();
    check("m0_master_rx", {24'h0, r0}, 32'h18);
    check("m0_valid", {31'h0, bus.rx_valid_o}, 32'h1);
    check("m0_no_err", {30'h0, bus.overrun_o, bus.underrun_o}, 32'h0);
    check("m0_oe_idle", {31'h0, bus.miso_oe_o}, 32'h0);
    rd_pulse();
    check("m0_valid_cleared", {31'h0, bus.rx_valid_o}, 32'h0);

    // mode 3, LSB first
    set_mode(1'b1, 1'b1, 1'b1);
    tx_load(8'hAA);
    exp_q.push_back(8'h55);
    frame(8'h55, 1'b0, r0);
    check("m3_master_rx", {24'h0, r0}, 32'hAA);
    check("m3_rx_data", {24'h0, bus.rx_data_o}, 32'h55);
    rd_pulse();

    // two bytes under one ss, no read in between
    set_mode(1'b0, 1'b0, 1'b0);
    tx_load(8'h5A);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    ss_low();
    spi_byte(8'h01, 1'b0, r0);
    spi_byte(8'h02, 1'b0, r1);
    ss_high();
    check("b2b_master_rx0", {24'h0, r0}, 32'h5A);
    check("b2b_master_rx1", {24'h0, r1}, 32'hFF);
    check("b2b_rx_data", {24'h0, bus.rx_data_o}, 32'h02);
    check("b2b_overrun", {31'h0, bus.overrun_o}, 32'h1);
    check("b2b_underrun", {31'h0, bus.underrun_o}, 32'h1);
    err_clr_pulse();
    check("b2b_err_cleared", {30'h0, bus.overrun_o, bus.underrun_o}, 32'h0);
    rd_pulse();

    // ss raised after three sclk edges
    a0 = abort_cnt;
    ss_low();
    bus.mosi_i = 1'b1;
    wait_n(H);
    bus.sclk_i = 1'b1; wait_n(H);
    bus.sclk_i = 1'b0; wait_n(H);
    bus.sclk_i = 1'b1; wait_n(H);
    bus.ss_i = 1'b1;
    wait_n(H);
    bus.sclk_i = 1'b0;
    wait_n(2 * H);
    check("abort_pulses", abort_cnt - a0, 32'd1);
    check("abort_no_valid", {31'h0, bus.rx_valid_o}, 32'h0);
    check("abort_state", {30'h0, bus.state}, {30'h0, IDLE});
    check("abort_underrun", {31'h0, bus.underrun_o}, 32'h1);
    err_clr_pulse();
    tx_load(8'h96);
    exp_q.push_back(8'h69);
    frame(8'h69, 1'b0, r0);
    check("post_abort_master_rx", {24'h0, r0}, 32'h96);
    check("post_abort_flags", {29'h0, bus.overrun_o, bus.underrun_o, bus.abort_o}, 32'h0);
    rd_pulse();

    // rx_rd_i coinciding with byte done
    tx_load(8'h21);
    exp_q.push_back(8'h11);
    frame(8'h11, 1'b0, r0);
    tx_load(8'h12);
    exp_q.push_back(8'h22);
    frame(8'h22, 1'b1, r1);
    check("rdsim_master_rx", {24'h0, r1}, 32'h12);
    check("rdsim_valid", {31'h0, bus.rx_valid_o}, 32'h1);
    check("rdsim_no_overrun", {31'h0, bus.overrun_o}, 32'h0);
    exp_q.push_back(8'h44);
    frame(8'h44, 1'b0, r0);
    check("unload_master_rx", {24'h0, r0}, 32'hFF);
    check("unload_errs", {30'h0, bus.overrun_o, bus.underrun_o}, 32'h3);
    err_clr_pulse();
    check("errclr_errs", {30'h0, bus.overrun_o, bus.underrun_o}, 32'h0);

    // PRESET_n asserted mid-byte, rx_valid still set from the last frame
    tx_load(8'h77);
    ss_low();
    tx_load(8'h88);
    bus.mosi_i = 1'b1;
    wait_n(H);
    bus.sclk_i = 1'b1; wait_n(H);
    bus.sclk_i = 1'b0; wait_n(3);
    check("pre_rst_tx_ready", {31'h0, bus.tx_ready_o}, 32'h0);
    check("pre_rst_valid", {31'h0, bus.rx_valid_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_tx_ready", {31'h0, bus.tx_ready_o}, 32'h1);
    check("arst_rx_data", {24'h0, bus.rx_data_o}, 32'h0);
    check("arst_flags", {28'h0, bus.rx_valid_o, bus.overrun_o, bus.underrun_o, bus.abort_o}, 32'h0);
    check("arst_oe_miso", {30'h0, bus.miso_oe_o, bus.miso_o}, 32'h0);
    check("arst_state", {30'h0, bus.state}, {30'h0, IDLE});
    bus.ss_i = 1'b1;
    bus.sclk_i = 1'b0;
    wait_n(4);
    rst_n = 1'b1;
    wait_n(2);
    set_mode(1'b0, 1'b1, 1'b0);
    tx_load(8'h3C);
    exp_q.push_back(8'hC3);
    frame(8'hC3, 1'b0, r0);
    check("m1_master_rx", {24'h0, r0}, 32'h3C);
    check("m1_rx_data", {24'h0, bus.rx_data_o}, 32'hC3);
    rd_pulse();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
